// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for the sequential ALU.
//   master : requester/consumer side (drives in_valid, operands, out_ready)
//   slave  : ALU side (drives in_ready, out_valid, result, busy)
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [2:0]       funct3;
  logic             alt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, op1, op2, funct3, alt, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op1, op2, funct3, alt, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle RV32I/RV64I integer ALU with valid/ready handshakes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_seq_if.slave
//     in_valid/in_ready   request handshake (op1, op2, funct3, alt)
//     out_valid/out_ready result handshake (result)
//     busy                high while shifting or holding a result
// Non-shift ops finish on the accept edge; shifts iterate SHIFT_STEP bits/cycle.
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int SW1     = SHAMT_W + 1;
  // One extra bit so SHIFT_STEP == WIDTH is representable.
  localparam logic [SHAMT_W:0] STEP_C = SW1'(SHIFT_STEP);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_work, w_work_nxt;
  logic [SHAMT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]     r_result, w_result_nxt;
  logic                 r_left, w_left_nxt;
  logic                 r_arith, w_arith_nxt;

  logic                 w_is_shift;
  logic [SHAMT_W-1:0]   w_shamt;
  logic [WIDTH-1:0]     w_alu;
  logic [SHAMT_W-1:0]   w_step;
  logic signed [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0]     w_shifted;

  assign w_is_shift = (bus.funct3[1:0] == 2'b01);
  assign w_shamt    = bus.op2[SHAMT_W-1:0];

  // Single-cycle ops; shifts pass op1 through so shamt==0 needs no special path.
  always_comb begin
    w_alu = bus.op1;
    case (bus.funct3)
      3'b000:  w_alu = bus.alt ? bus.op1 - bus.op2 : bus.op1 + bus.op2;
      3'b010:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
      3'b011:  w_alu = {{(WIDTH-1){1'b0}}, (bus.op1 < bus.op2)};
      3'b100:  w_alu = bus.op1 ^ bus.op2;
      3'b110:  w_alu = bus.op1 | bus.op2;
      3'b111:  w_alu = bus.op1 & bus.op2;
      default: w_alu = bus.op1;
    endcase
  end

  // step = min(SHIFT_STEP, count); count < WIDTH so the narrow result always fits.
  assign w_step = ({1'b0, r_cnt} < STEP_C) ? r_cnt : STEP_C[SHAMT_W-1:0];
  // Kept in its own signed assignment so >>> is not demoted to a logical shift.
  // The working MSB is the captured op1 sign and is preserved by every SRA step.
  assign w_sra  = $signed(r_work) >>> w_step;
  always_comb begin
    if (r_left)       w_shifted = r_work << w_step;
    else if (r_arith) w_shifted = w_sra;
    else              w_shifted = r_work >> w_step;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_work_nxt   = r_work;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_left_nxt   = r_left;
    w_arith_nxt  = r_arith;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (w_is_shift && (w_shamt != '0)) begin
            w_work_nxt  = bus.op1;
            w_cnt_nxt   = w_shamt;
            w_left_nxt  = ~bus.funct3[2];
            w_arith_nxt = bus.funct3[2] & bus.alt;
            w_state_nxt = S_SHIFT;
          end else begin
            w_result_nxt = w_alu;
            w_state_nxt  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        w_work_nxt = w_shifted;
        w_cnt_nxt  = r_cnt - w_step;
        if (r_cnt == w_step) begin
          w_result_nxt = w_shifted;
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        // No accept here: one bubble per op.
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_work   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_left   <= 1'b0;
      r_arith  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_work   <= w_work_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_left   <= w_left_nxt;
      r_arith  <= w_arith_nxt;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.result    = r_result;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq. Three instances share clock/reset:
//   dut0 WIDTH=32 SHIFT_STEP=1, dut1 WIDTH=32 SHIFT_STEP=4, dut2 WIDTH=64 SHIFT_STEP=4.
// One set of stimulus regs drives all; 'sel' gates in_valid and picks outputs.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int sel   = 0;

  logic        tb_in_valid, tb_out_ready, tb_alt;
  logic [2:0]  tb_f3;
  logic [63:0] tb_op1, tb_op2;
  logic [63:0] exp_q[$];

  alu_seq_if #(.WIDTH(32)) bus0();
  alu_seq_if #(.WIDTH(32)) bus1();
  alu_seq_if #(.WIDTH(64)) bus2();

  assign bus0.in_valid = tb_in_valid && (sel == 0);
  assign bus1.in_valid = tb_in_valid && (sel == 1);
  assign bus2.in_valid = tb_in_valid && (sel == 2);
  assign bus0.op1 = tb_op1[31:0];  assign bus0.op2 = tb_op2[31:0];
  assign bus1.op1 = tb_op1[31:0];  assign bus1.op2 = tb_op2[31:0];
  assign bus2.op1 = tb_op1;        assign bus2.op2 = tb_op2;
  assign bus0.funct3 = tb_f3; assign bus1.funct3 = tb_f3; assign bus2.funct3 = tb_f3;
  assign bus0.alt = tb_alt;   assign bus1.alt = tb_alt;   assign bus2.alt = tb_alt;
  assign bus0.out_ready = tb_out_ready;
  assign bus1.out_ready = tb_out_ready;
  assign bus2.out_ready = tb_out_ready;

  alu_seq #(.WIDTH(32), .SHIFT_STEP(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  alu_seq #(.WIDTH(32), .SHIFT_STEP(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_seq #(.WIDTH(64), .SHIFT_STEP(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic        w_in_ready, w_out_valid, w_busy;
  logic [63:0] w_result;
  always_comb begin
    w_in_ready  = bus0.in_ready;
    w_out_valid = bus0.out_valid;
    w_busy      = bus0.busy;
    w_result    = {32'h0, bus0.result};
    if (sel == 1) begin
      w_in_ready  = bus1.in_ready;
      w_out_valid = bus1.out_valid;
      w_busy      = bus1.busy;
      w_result    = {32'h0, bus1.result};
    end else if (sel == 2) begin
      w_in_ready  = bus2.in_ready;
      w_out_valid = bus2.out_valid;
      w_busy      = bus2.busy;
      w_result    = bus2.result;
    end
  end

  // Reference model, bit-serial for right shifts, offset-binary for SLT.
  function automatic logic [63:0] model(input int w, input logic [2:0] f3, input logic a_alt,
                                        input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, a, b, r, sb;
    int sh;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a  = a_in & mask;
    b  = b_in & mask;
    sb = 64'h1 << (w - 1);
    sh = int'(b & 64'(w - 1));
    case (f3)
      3'b000: r = a_alt ? a - b : a + b;
      3'b001: r = a << sh;
      3'b010: r = ((a ^ sb) < (b ^ sb)) ? 64'h1 : 64'h0;
      3'b011: r = (a < b) ? 64'h1 : 64'h0;
      3'b100: r = a ^ b;
      3'b101: begin
        r = a;
        for (int i = 0; i < sh; i++) r = (r >> 1) | ((a_alt && (a & sb) != 0) ? sb : 64'h0);
      end
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    return r & mask;
  endfunction

  task automatic issue(input int d, input logic [2:0] f3, input logic a_alt,
                       input logic [63:0] x, input logic [63:0] y, input logic [63:0] e);
    int cyc = 0;
    sel = d; tb_f3 = f3; tb_alt = a_alt; tb_op1 = x; tb_op2 = y; tb_in_valid = 1'b1;
    while (!w_in_ready && cyc < 300) begin @(posedge clk); #1; cyc++; end
    if (!w_in_ready) begin
      total++; bad++;
      $display("FAIL issue_timeout in_ready=%0b want 1", w_in_ready);
    end
    @(posedge clk); #1;
    // Scramble inputs after accept; the DUT must have captured them.
    tb_in_valid = 1'b0; tb_op1 = ~x; tb_op2 = ~y; tb_f3 = ~f3; tb_alt = ~a_alt;
    exp_q.push_back(e);
  endtask

  // Called right after issue: measures latency (accept edge counts as 1), checks
  // in_ready stays low until the result, compares against the scoreboard, consumes.
  task automatic collect(input string nm, input int lat_exp);
    int lat = 1;
    int rdy = 0;
    logic [63:0] e;
    while (!w_out_valid && lat < 300) begin
      if (w_in_ready) rdy++;
      @(posedge clk); #1; lat++;
    end
    if (w_in_ready) rdy++;
    total++;
    if (w_out_valid !== 1'b1) begin bad++; $display("FAIL %s out_valid_timeout got=%0b want 1", nm, w_out_valid); end
    total++;
    if (lat !== lat_exp) begin bad++; $display("FAIL %s latency got=%0d want %0d", nm, lat, lat_exp); end
    total++;
    if (rdy !== 0) begin bad++; $display("FAIL %s in_ready_high_cycles got=%0d want 0", nm, rdy); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    total++;
    if (w_result !== e) begin bad++; $display("FAIL %s result got=%h want %h", nm, w_result, e); end
    tb_out_ready = 1'b1; @(posedge clk); #1; tb_out_ready = 1'b0;
    total++;
    if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1)
      begin bad++; $display("FAIL %s consume valid=%0b ready=%0b want 0/1", nm, w_out_valid, w_in_ready); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tb_in_valid = 1'b0; tb_out_ready = 1'b0; tb_alt = 1'b0;
    tb_f3 = 3'b000; tb_op1 = '0; tb_op2 = '0; sel = 0;
    #12;
    total++;
    if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0 || bus0.busy !== 1'b0 || bus0.result !== 32'h0)
      begin bad++; $display("FAIL reset_dut0 rdy=%0b vld=%0b busy=%0b res=%h want 1/0/0/0",
                            bus0.in_ready, bus0.out_valid, bus0.busy, bus0.result); end
    total++;
    if (bus2.in_ready !== 1'b1 || bus2.out_valid !== 1'b0 || bus2.result !== 64'h0)
      begin bad++; $display("FAIL reset_dut2 rdy=%0b vld=%0b res=%h want 1/0/0",
                            bus2.in_ready, bus2.out_valid, bus2.result); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    issue(0, 3'b000, 1'b0, 64'hFFFF_FFFF, 64'h1, 64'h0);          collect("add_wrap", 1);
    issue(0, 3'b000, 1'b1, 64'h5, 64'h7, 64'hFFFF_FFFE);          collect("sub_neg", 1);
  endtask

  task automatic test_slt();
    issue(0, 3'b010, 1'b0, 64'h8000_0000, 64'h1, 64'h1);          collect("slt_neg", 1);
    issue(0, 3'b011, 1'b0, 64'h8000_0000, 64'h1, 64'h0);          collect("sltu", 1);
    issue(0, 3'b010, 1'b0, 64'h7FFF_FFFF, 64'h7FFF_FFFF, 64'h0);  collect("slt_eq", 1);
    issue(0, 3'b010, 1'b0, 64'h8000_0000, 64'h0, 64'h1);          collect("slt_minneg", 1);
  endtask

  task automatic test_shift();
    issue(0, 3'b101, 1'b1, 64'h8000_0010, 64'h4, 64'hF800_0001);  collect("sra4_s1", 5);
    issue(0, 3'b101, 1'b1, 64'h8000_0000, 64'h1F, 64'hFFFF_FFFF); collect("sra31_s1", 32);
    issue(0, 3'b001, 1'b0, 64'h1, 64'd33, 64'h2);                 collect("sll_op2hi", 2);
    issue(1, 3'b001, 1'b0, 64'h3, 64'h3F, 64'h8000_0000);         collect("sll31_s4", 9);
    issue(1, 3'b001, 1'b0, 64'h1234_5678, 64'h20, 64'h1234_5678); collect("sll0_s4", 1);
    issue(1, 3'b101, 1'b0, 64'h8000_0000, 64'h5, 64'h0400_0000);  collect("srl5_s4", 3);
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    issue(0, 3'b100, 1'b0, 64'hF0F0_F0F0, 64'hFFFF_0000, 64'h0F0F_F0F0);
    while (!w_out_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    // Offer a new ADD while the result is held; it must wait for the bubble.
    tb_f3 = 3'b000; tb_alt = 1'b0; tb_op1 = 64'd10; tb_op2 = 64'd20; tb_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (w_out_valid !== 1'b1 || w_in_ready !== 1'b0 || w_result !== 64'h0F0F_F0F0)
        begin bad++; $display("FAIL bp_hold[%0d] vld=%0b rdy=%0b res=%h want 1/0/0f0ff0f0",
                              i, w_out_valid, w_in_ready, w_result); end
      @(posedge clk); #1;
    end
    tb_out_ready = 1'b1; @(posedge clk); #1; tb_out_ready = 1'b0;
    void'(exp_q.pop_front());
    total++;
    if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1)
      begin bad++; $display("FAIL bp_release vld=%0b rdy=%0b want 0/1", w_out_valid, w_in_ready); end
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    exp_q.push_back(64'd30);
    collect("bp_next_add", 1);
  endtask

  task automatic test_reset_mid();
    issue(0, 3'b101, 1'b0, 64'hFFFF_0000, 64'd20, 64'h0000_0FFF);
    void'(exp_q.pop_back());
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0; #1;
    total++;
    if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1 || w_result !== 64'h0 || w_busy !== 1'b0)
      begin bad++; $display("FAIL rst_mid vld=%0b rdy=%0b res=%h busy=%0b want 0/1/0/0",
                            w_out_valid, w_in_ready, w_result, w_busy); end
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (w_out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_noresult vld=%0b want 0", w_out_valid); end
    issue(0, 3'b000, 1'b0, 64'd2, 64'd3, 64'd5);                  collect("add_after_rst", 1);
  endtask

  task automatic test_w64();
    issue(2, 3'b101, 1'b1, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF);
    collect("sra63_w64", 17);
    issue(2, 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h1);
    collect("add_w64", 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  f3;
      logic        a_alt;
      logic [63:0] x, y;
      int          sh, lat;
      f3 = 3'($urandom_range(0, 7));
      a_alt = 1'($urandom_range(0, 1));
      x = {32'h0, $urandom()};
      y = (i % 3 == 0) ? {32'h0, $urandom()} : 64'($urandom_range(0, 40));
      sh = int'(y[4:0]);
      lat = ((f3 == 3'b001 || f3 == 3'b101) && sh != 0) ? 1 + (sh + 3) / 4 : 1;
      issue(1, f3, a_alt, x, y, model(32, f3, a_alt, x, y));
      collect("rand_s4", lat);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_slt();
    test_shift();
    test_backpressure();
    test_reset_mid();
    test_w64();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
